rf_port_arbiter: RTL and testbench

- Shares the single access port of the 32x32 register file (re/we mutually exclusive, re has priority) between three requesters: decode-stage read, writeback write, debug access.
- Writeback writes are buffered in a small queue so WB stalls only when the queue is full.
- Reads are pipelined with a fixed 2-cycle latency.
- RAW hazards against queued writes are stalled, or forwarded when the optional bypass is enabled.
- Sits between pipeline control and the register file; owns all rf_* control signals.

---
 rtl/rf_arb_pkg.sv | 21 ++
 rtl/rf_wr_queue.sv | 102 ++++++++++
 rtl/rf_port_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_rf_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file port arbiter: default widths, the
// per-cycle grant encoding and the read-pipeline tag.
package rf_arb_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  typedef enum logic [2:0] {
    GNT_NONE    = 3'd0,
    GNT_WR_FULL = 3'd1,
    GNT_DBG     = 3'd2,
    GNT_RD      = 3'd3,
    GNT_WR      = 3'd4
  } grant_e;

  typedef enum logic {
    TAG_RD  = 1'b0,
    TAG_DBG = 1'b1
  } tag_e;

endpackage

// File: rtl/rf_wr_queue.sv
// Circular write-back queue. Besides push/pop it reports, per read port,
// which valid entries match the read address and the data of the youngest
// matching entry (address 0 never matches).
module rf_wr_queue
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = RF_DW,
  parameter int AW    = RF_AW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [AW-1:0]            push_addr_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [AW-1:0]            head_addr_o,
  output logic [DW-1:0]            head_data_o,
  input  logic [AW-1:0]            raddr1_i,
  input  logic [AW-1:0]            raddr2_i,
  output logic [DEPTH-1:0]         match1_o,
  output logic [DEPTH-1:0]         match2_o,
  output logic                     hit1_o,
  output logic                     hit2_o,
  output logic [DW-1:0]            hit_data1_o,
  output logic [DW-1:0]            hit_data2_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] idx_s;

  // Occupancy next state: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CW'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Pointer and occupancy registers; reset discards all queued entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + PW'(1);
      if (pop_i)  head_q <= head_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Entry storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  // Walk entries oldest to youngest so the last match seen is the youngest.
  always_comb begin
    match1_o    = '0;
    match2_o    = '0;
    hit1_o      = 1'b0;
    hit2_o      = 1'b0;
    hit_data1_o = '0;
    hit_data2_o = '0;
    idx_s       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = head_q + PW'(k);
      if (CW'(k) < count_q) begin
        if ((raddr1_i != '0) && (addr_q[idx_s] == raddr1_i)) begin
          match1_o[idx_s] = 1'b1;
          hit1_o          = 1'b1;
          hit_data1_o     = data_q[idx_s];
        end
        if ((raddr2_i != '0) && (addr_q[idx_s] == raddr2_i)) begin
          match2_o[idx_s] = 1'b1;
          hit2_o          = 1'b1;
          hit_data2_o     = data_q[idx_s];
        end
      end
    end
  end

  assign count_o     = count_q;
  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];

endmodule

// File: rtl/rf_port_arbiter.sv
// Arbitrates the single register-file port between decode reads, queued
// writeback writes and debug accesses. Reads have a fixed 2-cycle latency.
// Optional build macro RF_ARB_BYPASS_EN: forward queued write data to reads
// instead of stalling them on address hazards.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int WQ_DEPTH = 4,
  parameter int DW       = RF_DW,
  parameter int AW       = RF_AW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rd_req,
  input  logic [AW-1:0]              rd_addr1,
  input  logic [AW-1:0]              rd_addr2,
  output logic                       rd_ack,
  output logic                       rd_valid,
  output logic [DW-1:0]              rd_data1,
  output logic [DW-1:0]              rd_data2,
  input  logic                       wr_req,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DW-1:0]              wr_data,
  output logic                       wr_ready,
  input  logic                       dbg_req,
  input  logic                       dbg_we,
  input  logic [AW-1:0]              dbg_addr,
  input  logic [DW-1:0]              dbg_wdata,
  output logic                       dbg_ack,
  output logic                       dbg_rvalid,
  output logic [DW-1:0]              dbg_rdata,
  output logic                       rf_re,
  output logic                       rf_we,
  output logic [AW-1:0]              rf_raddr1,
  output logic [AW-1:0]              rf_raddr2,
  output logic [AW-1:0]              rf_waddr,
  output logic [DW-1:0]              rf_wdata,
  input  logic [DW-1:0]              rf_rdata1,
  input  logic [DW-1:0]              rf_rdata2,
  output logic [$clog2(WQ_DEPTH):0]  wq_count
);

  localparam int CW = $clog2(WQ_DEPTH) + 1;

`ifdef RF_ARB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  grant_e                gnt_s;
  logic                  full_s, empty_s, hazard_s, push_s, pop_s;
  logic [AW-1:0]         head_addr_s;
  logic [DW-1:0]         head_data_s;
  logic [WQ_DEPTH-1:0]   match1_s, match2_s;
  logic                  hit1_s, hit2_s;
  logic [DW-1:0]         hit_data1_s, hit_data2_s;

  // Read pipeline stage 1 (issue -> RF data available) and output stage.
  logic                  s1_valid_q, s1_valid_d;
  tag_e                  s1_tag_q, s1_tag_d;
  logic                  s1_hit1_q, s1_hit1_d, s1_hit2_q, s1_hit2_d;
  logic [DW-1:0]         s1_snap1_q, s1_snap1_d, s1_snap2_q, s1_snap2_d;
  logic                  rd_valid_q, rd_valid_d, dbg_rvalid_q, dbg_rvalid_d;
  logic [DW-1:0]         rd_data1_q, rd_data1_d, rd_data2_q, rd_data2_d;
  logic [DW-1:0]         dbg_rdata_q, dbg_rdata_d;

  rf_wr_queue #(
    .DEPTH (WQ_DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_wq (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_s),
    .push_addr_i (wr_addr),
    .push_data_i (wr_data),
    .pop_i       (pop_s),
    .count_o     (wq_count),
    .head_addr_o (head_addr_s),
    .head_data_o (head_data_s),
    .raddr1_i    (rd_addr1),
    .raddr2_i    (rd_addr2),
    .match1_o    (match1_s),
    .match2_o    (match2_s),
    .hit1_o      (hit1_s),
    .hit2_o      (hit2_s),
    .hit_data1_o (hit_data1_s),
    .hit_data2_o (hit_data2_s)
  );

  // Ready depends only on the registered count; writes to r0 complete the
  // handshake but are dropped since r0 is hard-wired.
  assign full_s   = (wq_count == CW'(WQ_DEPTH));
  assign empty_s  = (wq_count == '0);
  assign wr_ready = !reset && !full_s;
  assign push_s   = wr_req && wr_ready && (wr_addr != '0);
  assign pop_s    = (gnt_s == GNT_WR_FULL) || (gnt_s == GNT_WR);
  assign hazard_s = !BYPASS && ((|match1_s) || (|match2_s));

  // Single grant per cycle in fixed priority order.
  always_comb begin
    gnt_s = GNT_NONE;
    if (reset) begin
      gnt_s = GNT_NONE;
    end else if (full_s) begin
      gnt_s = GNT_WR_FULL;
    end else if (dbg_req && empty_s) begin
      gnt_s = GNT_DBG;
    end else if (rd_req && !hazard_s) begin
      gnt_s = GNT_RD;
    end else if (!empty_s) begin
      gnt_s = GNT_WR;
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  // Drive the register-file port and handshakes from the grant.
  always_comb begin
    rf_re     = 1'b0;
    rf_we     = 1'b0;
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    rd_ack    = 1'b0;
    dbg_ack   = 1'b0;
    case (gnt_s)
      GNT_WR_FULL, GNT_WR: begin
        rf_we    = 1'b1;
        rf_waddr = head_addr_s;
        rf_wdata = head_data_s;
      end
      GNT_DBG: begin
        dbg_ack = 1'b1;
        if (dbg_we) begin
          rf_we    = 1'b1;
          rf_waddr = dbg_addr;
          rf_wdata = dbg_wdata;
        end else begin
          rf_re     = 1'b1;
          rf_raddr1 = dbg_addr;
        end
      end
      GNT_RD: begin
        rd_ack    = 1'b1;
        rf_re     = 1'b1;
        rf_raddr1 = rd_addr1;
        rf_raddr2 = rd_addr2;
      end
      default: begin
        rf_re = 1'b0;
      end
    endcase
  end

  // Stage-1 next state: tag the issued read and snapshot forwarded data.
  always_comb begin
    s1_valid_d = rf_re;
    s1_tag_d   = (gnt_s == GNT_DBG) ? TAG_DBG : TAG_RD;
    s1_hit1_d  = BYPASS && (gnt_s == GNT_RD) && hit1_s;
    s1_hit2_d  = BYPASS && (gnt_s == GNT_RD) && hit2_s;
    s1_snap1_d = hit_data1_s;
    s1_snap2_d = hit_data2_s;
  end

  // Capture stage: RF data (or forwarded snapshot) lands in output registers.
  always_comb begin
    rd_valid_d   = s1_valid_q && (s1_tag_q == TAG_RD);
    dbg_rvalid_d = s1_valid_q && (s1_tag_q == TAG_DBG);
    rd_data1_d   = rd_data1_q;
    rd_data2_d   = rd_data2_q;
    dbg_rdata_d  = dbg_rdata_q;
    if (rd_valid_d) begin
      rd_data1_d = s1_hit1_q ? s1_snap1_q : rf_rdata1;
      rd_data2_d = s1_hit2_q ? s1_snap2_q : rf_rdata2;
    end else begin
      rd_data1_d = rd_data1_q;
      rd_data2_d = rd_data2_q;
    end
    if (dbg_rvalid_d) begin
      dbg_rdata_d = rf_rdata1;
    end else begin
      dbg_rdata_d = dbg_rdata_q;
    end
  end

  // Read pipeline registers; reset drops anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_tag_q     <= TAG_RD;
      s1_hit1_q    <= 1'b0;
      s1_hit2_q    <= 1'b0;
      s1_snap1_q   <= '0;
      s1_snap2_q   <= '0;
      rd_valid_q   <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      rd_data1_q   <= '0;
      rd_data2_q   <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_tag_q     <= s1_tag_d;
      s1_hit1_q    <= s1_hit1_d;
      s1_hit2_q    <= s1_hit2_d;
      s1_snap1_q   <= s1_snap1_d;
      s1_snap2_q   <= s1_snap2_d;
      rd_valid_q   <= rd_valid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      rd_data1_q   <= rd_data1_d;
      rd_data2_q   <= rd_data2_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data1   = rd_data1_q;
  assign rd_data2   = rd_data2_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a behavioural register file.
// Expected read results and RF writes go into queues; a negedge monitor
// pops and compares whenever the DUT presents rd_valid, dbg_rvalid or rf_we.
module tb_rf_port_arbiter;

  localparam int D  = 4;
  localparam int DW = 32;
  localparam int AW = 5;

`ifdef RF_ARB_BYPASS_EN
  localparam int HAZ_DELAY = 0;
  localparam int YNG_DELAY = 0;
`else
  localparam int HAZ_DELAY = 1;
  localparam int YNG_DELAY = 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rd_req = 1'b0, wr_req = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0, dbg_addr = '0;
  logic [DW-1:0] wr_data = '0, dbg_wdata = '0;
  logic rd_ack, rd_valid, wr_ready, dbg_ack, dbg_rvalid, rf_re, rf_we;
  logic [DW-1:0] rd_data1, rd_data2, dbg_rdata, rf_wdata;
  logic [DW-1:0] rf_rdata1 = '0, rf_rdata2 = '0;
  logic [AW-1:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic [$clog2(D):0] wq_count;

  typedef struct { logic [DW-1:0] d1; logic [DW-1:0] d2; int cyc; } rd_exp_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_exp_t;
  rd_exp_t       rd_q[$];
  wr_exp_t       wr_q[$];
  logic [DW-1:0] dbg_q[$];

  logic [DW-1:0] rf_mem [32];
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  rf_port_arbiter #(.WQ_DEPTH(D), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .rf_re(rf_re), .rf_we(rf_we), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1),
    .rf_rdata2(rf_rdata2), .wq_count(wq_count)
  );

  always #5 clk = ~clk;

  // Cycle counter: value seen during a cycle identifies that cycle.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register file with registered read data.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
      rf_rdata1 <= '0;
      rf_rdata2 <= '0;
    end else begin
      if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
      if (rf_re) begin
        rf_rdata1 <= rf_mem[rf_raddr1];
        rf_rdata2 <= rf_mem[rf_raddr2];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!reset) begin
      if (rf_re && rf_we) fail_now("re_we_both_high");
      if (rd_valid) begin
        if (rd_q.size() == 0) fail_now("unexpected_rd_valid");
        else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          chk("rd_data1", rd_data1, e.d1);
          chk("rd_data2", rd_data2, e.d2);
          chk("rd_latency_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (dbg_rvalid) begin
        if (dbg_q.size() == 0) fail_now("unexpected_dbg_rvalid");
        else chk("dbg_rdata", dbg_rdata, dbg_q.pop_front());
      end
      if (rf_we) begin
        if (wr_q.size() == 0) fail_now("unexpected_rf_we");
        else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          chk("rf_waddr", 32'(rf_waddr), 32'(w.a));
          chk("rf_wdata", rf_wdata, w.d);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 1'b0;
    wr_q.push_back('{a, d});
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (dbg_ack) got = 1'b1;
    end
    if (!got) fail_now("dbg_write_timeout");
    next_cycle();
    dbg_req = 1'b0; dbg_we = 1'b0;
  endtask

  task automatic dbg_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
    bit got = 1'b0;
    dbg_q.push_back(e);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = a;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (dbg_ack) got = 1'b1;
    end
    if (!got) fail_now("dbg_read_timeout");
    next_cycle();
    dbg_req = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                         output int ack_cyc);
    bit got = 1'b0;
    ack_cyc = -1;
    rd_req = 1'b1; rd_addr1 = a1; rd_addr2 = a2;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rd_ack) begin
        got = 1'b1;
        ack_cyc = cyc;
        rd_q.push_back('{e1, e2, cyc + 2});
      end
    end
    if (!got) fail_now("read_ack_timeout");
    next_cycle();
    rd_req = 1'b0;
  endtask

  task automatic wb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 1'b0;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (wr_ready) begin
        got = 1'b1;
        if (a != '0) wr_q.push_back('{a, d});
      end
    end
    if (!got) fail_now("wb_write_timeout");
    next_cycle();
    wr_req = 1'b0;
  endtask

  initial begin
    int ack_c, start_c, wi;
    logic [AW-1:0] wa [5];
    logic [DW-1:0] wd [5];
    wa[0] = 5'd1; wa[1] = 5'd2; wa[2] = 5'd4; wa[3] = 5'd6; wa[4] = 5'd8;
    wd[0] = 32'hA1; wd[1] = 32'hA2; wd[2] = 32'hA4; wd[3] = 32'hA6; wd[4] = 32'hA8;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_wq_count", 32'(wq_count), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("wr_ready_after_rst", 32'(wr_ready), 32'd1);
    next_cycle();

    // Basic read with 2-cycle latency, r0 reads as 0, debug read path
    dbg_write(5'd5, 32'h11);
    dbg_write(5'd9, 32'h99);
    do_read(5'd5, 5'd0, 32'h11, 32'h0, ack_c);
    dbg_read(5'd5, 32'h11);
    repeat (4) next_cycle();

    // Fill the queue while reads hold the port; 5th write held, then WR_FULL
    rd_req = 1'b1; rd_addr1 = 5'd9; rd_addr2 = 5'd0;
    wr_req = 1'b1; wi = 0; wr_addr = wa[0]; wr_data = wd[0];
    for (int c = 0; c < 12 && wi < 5; c++) begin
      @(negedge clk);
      if (c == 4) begin
        chk("full_wq_count", 32'(wq_count), 32'd4);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        chk("full_rf_we", 32'(rf_we), 32'd1);
        chk("full_rd_ack", 32'(rd_ack), 32'd0);
      end
      if (rd_ack) rd_q.push_back('{32'h99, 32'h0, cyc + 2});
      if (wr_ready) begin
        wr_q.push_back('{wa[wi], wd[wi]});
        wi++;
      end
      next_cycle();
      if (wi < 5) begin
        wr_addr = wa[wi]; wr_data = wd[wi];
      end else begin
        wr_req = 1'b0;
      end
    end
    chk("fill_all_accepted", 32'(wi), 32'd5);
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (8) next_cycle();
    @(negedge clk);
    chk("drained_wq_count", 32'(wq_count), 32'd0);
    next_cycle();

    // RAW hazard on a queued write: stall (or forward)
    wb_write(5'd7, 32'hAA);
    start_c = cyc;
    do_read(5'd7, 5'd0, 32'hAA, 32'h0, ack_c);
    chk("hazard_ack_delay", 32'(ack_c - start_c), 32'(HAZ_DELAY));
    repeat (4) next_cycle();

    // Two queued writes to r3: the read must see the youngest
    rd_req = 1'b1; rd_addr1 = 5'd9; rd_addr2 = 5'd0;
    wr_req = 1'b1; wr_addr = 5'd3; wr_data = 32'h1;
    @(negedge clk);
    chk("yng_rd_ack0", 32'(rd_ack), 32'd1);
    rd_q.push_back('{32'h99, 32'h0, cyc + 2});
    wr_q.push_back('{5'd3, 32'h1});
    next_cycle();
    wr_data = 32'h2;
    @(negedge clk);
    chk("yng_rd_ack1", 32'(rd_ack), 32'd1);
    rd_q.push_back('{32'h99, 32'h0, cyc + 2});
    wr_q.push_back('{5'd3, 32'h2});
    next_cycle();
    wr_req = 1'b0;
    start_c = cyc;
    do_read(5'd3, 5'd9, 32'h2, 32'h99, ack_c);
    chk("youngest_ack_delay", 32'(ack_c - start_c), 32'(YNG_DELAY));
    repeat (6) next_cycle();

    // Write enqueued in the same cycle as the read is not a hazard: old value
    rd_req = 1'b1; rd_addr1 = 5'd3; rd_addr2 = 5'd0;
    wr_req = 1'b1; wr_addr = 5'd3; wr_data = 32'h5;
    @(negedge clk);
    chk("same_cycle_rd_ack", 32'(rd_ack), 32'd1);
    rd_q.push_back('{32'h2, 32'h0, cyc + 2});
    chk("same_cycle_wr_ready", 32'(wr_ready), 32'd1);
    wr_q.push_back('{5'd3, 32'h5});
    next_cycle();
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (5) next_cycle();

    // Write to r0: handshake completes, nothing queued or written
    wb_write(5'd0, 32'hFF);
    @(negedge clk);
    chk("r0_wq_count", 32'(wq_count), 32'd0);
    repeat (4) next_cycle();

    // Reset mid-operation: in-flight reads dropped, queue discarded
    rd_req = 1'b1; rd_addr1 = 5'd9; rd_addr2 = 5'd0;
    wr_req = 1'b1; wr_addr = 5'd10; wr_data = 32'hB1;
    @(negedge clk);
    chk("rst_mid_ack0", 32'(rd_ack), 32'd1);
    rd_q.push_back('{32'h99, 32'h0, cyc + 2});
    next_cycle();
    wr_addr = 5'd11; wr_data = 32'hB2;
    @(negedge clk);
    chk("rst_mid_ack1", 32'(rd_ack), 32'd1);
    next_cycle();
    wr_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack2", 32'(rd_ack), 32'd1);
    chk("rst_mid_wq_count", 32'(wq_count), 32'd2);
    next_cycle();
    reset = 1'b1; rd_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_cleared_count", 32'(wq_count), 32'd0);
    chk("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_mid_wr_ready", 32'(wr_ready), 32'd0);
    repeat (2) next_cycle();
    reset = 1'b0;
    repeat (8) next_cycle();
    @(negedge clk);
    chk("post_rst_wq_count", 32'(wq_count), 32'd0);

    chk("rd_exp_left", 32'(rd_q.size()), 32'd0);
    chk("wr_exp_left", 32'(wr_q.size()), 32'd0);
    chk("dbg_exp_left", 32'(dbg_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "time limit reached");
  end

endmodule
